ysyx_22041412_axi_dbridge: RTL

YSYX_22041412_AXI_DBRIDGE -- requirements
Module: ysyx_22041412_axi_dbridge
Interface
REQ-001 SHALL have parameter: ADDR_WIDTH, 32, address width of both request sides.
REQ-002 SHALL have parameter: DATA_WIDTH, 64, data width of both request sides.
REQ-003 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port: rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port: r_valid_i  input  1  Dcache read (refill) request.
REQ-006 SHALL have port: r_addr_i  input  ADDR_WIDTH  read start address.
REQ-007 SHALL have port: r_len_i  input  8  read beats minus one.
REQ-008 SHALL have port: r_ready_o  output  1  pulse per returned read beat.
REQ-009 SHALL have port: r_last_o  output  1  pulse with the final read beat.
REQ-010 SHALL have port: r_data_o  output  DATA_WIDTH  read beat data.
REQ-011 SHALL have port: w_valid_i  input  1  Dcache write (writeback or store) request.
REQ-012 SHALL have port: w_addr_i  input  ADDR_WIDTH  write start address.
REQ-013 SHALL have port: w_size_i  input  3  func3-style size, 0=B, 1=H, 2=W, 3=D.
REQ-014 SHALL have port: w_len_i  input  8  write beats minus one.
REQ-015 SHALL have port: w_data_i  input  DATA_WIDTH  current write beat.
REQ-016 SHALL have port: w_ready_o  output  1  current write beat consumed; Dcache advances data.
REQ-017 SHALL have port: w_last_o  output  1  pulse when the write response is received.
REQ-018 SHALL have port: arvalid / arready  output / input  1 / 1  AXI read address handshake (one line each in RTL).
REQ-019 SHALL have port: araddr, arlen  output  ADDR_WIDTH, 8  AXI read address and length.
REQ-020 SHALL have port: rvalid / rready  input / output  1 / 1  AXI read data handshake.
REQ-021 SHALL have port: rdata, rlast  input  DATA_WIDTH, 1  AXI read data and last flag.
REQ-022 SHALL have port: awvalid / awready  output / input  1 / 1  AXI write address handshake.
REQ-023 SHALL have port: awaddr, awlen  output  ADDR_WIDTH, 8  AXI write address and length.
REQ-024 SHALL have port: wvalid / wready  output / input  1 / 1  AXI write data handshake.
REQ-025 SHALL have port: wdata, wstrb, wlast  output  DATA_WIDTH, 8, 1  AXI write beat.
REQ-026 SHALL have port: bvalid / bready  input / output  1 / 1  AXI write response handshake.
Function
REQ-027 SHALL implement FSM IDLE, RD_AR, RD_R, WR_AW, WR_W, WR_B, DONE, with one transaction outstanding at a time.
REQ-028 SHALL, in IDLE, go to WR_AW if w_valid_i, else to RD_AR if r_valid_i (write wins ties), latching addr, len, size into registers; request inputs other than w_data_i are ignored outside IDLE.
REQ-029 SHALL hold arvalid=1 with latched araddr/arlen in RD_AR until the arready handshake, then go to RD_R.
REQ-030 SHALL hold rready=1 in RD_R; each rvalid&&rready beat registers rdata into r_data_o and pulses r_ready_o for one cycle the cycle after; r_last_o pulses with the beat carrying rlast; the rlast handshake goes to DONE.
REQ-031 SHALL hold awvalid=1 in WR_AW until awready, then go to WR_W with the 8-bit beat counter at 0.
REQ-032 SHALL drive in WR_W: wvalid=1, wdata=w_data_i, wlast=(counter==latched len); w_ready_o=wvalid&&wready (combinational); the counter increments per handshake; the wlast handshake goes to WR_B.
REQ-033 SHALL set wstrb = {01,03,0F,FF}[size[1:0]] shifted left by latched addr[2:0] when len==0, and 8'hFF when len>0.
REQ-034 SHALL assert bready=1 in WR_B; the bvalid handshake pulses w_last_o for one cycle and goes to DONE.
REQ-035 SHALL spend exactly one cycle in DONE, ignoring request valids, then return to IDLE, so the Dcache can drop valid without a duplicate transaction.
REQ-036 SHALL treat len=0 as a single beat and len=255 as 256 beats, with no counter wrap before wlast.
Reset
REQ-037 SHALL, while rst=0 at a rising edge, force state IDLE, counter 0, and all outputs 0 (r_data_o included), abandoning any in-flight AXI transaction.
Verification
REQ-038 SHALL pass: read, r_addr_i=0x80001000, len=3, arready delayed 2 cycles, 4 beats -> araddr held stable; 4 r_ready_o pulses; r_last_o on beat 4 only; DONE then IDLE.
REQ-039 SHALL pass: write, w_addr_i=0x80000006, size=1, len=0 -> wstrb=8'hC0, wlast=1, w_last_o one cycle after bvalid.
REQ-040 SHALL pass: w_valid_i and r_valid_i rise in the same cycle -> AW issued first; AR issued only after the DONE cycle.
REQ-041 SHALL pass: write len=7 with wready toggling every cycle -> exactly 8 w_ready_o pulses, wlast only on the 8th beat, wstrb=8'hFF.
REQ-042 SHALL pass: rst=0 during RD_R beat 2 -> next cycle all outputs 0 and state IDLE; a new request is accepted normally afterwards.

---
 rtl/ysyx_22041412_axi_dbridge_if.sv | 38 +++
 rtl/ysyx_22041412_axi_dbridge.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ysyx_22041412_axi_dbridge_if.sv
// AXI4 master-side bus bundle for the Dcache bridge: AR/R read channels and
// AW/W/B write channels, with master (bridge) and slave (memory) views.
interface ysyx_22041412_axi_dbridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
);
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rlast;
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic                  wvalid;
  logic                  wready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [7:0]            wstrb;
  logic                  wlast;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output arvalid, araddr, arlen, rready,
    output awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
    input  arready, rvalid, rdata, rlast, awready, wready, bvalid
  );

  modport slave (
    input  arvalid, araddr, arlen, rready,
    input  awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
    output arready, rvalid, rdata, rlast, awready, wready, bvalid
  );
endinterface

// File: rtl/ysyx_22041412_axi_dbridge.sv
// Dcache-to-AXI bridge: one burst read or burst write in flight at a time,
// followed by a single DONE cycle so a lingering request valid is not reissued.
module ysyx_22041412_axi_dbridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r_valid_i,
  input  logic [ADDR_WIDTH-1:0] r_addr_i,
  input  logic [7:0]            r_len_i,
  output logic                  r_ready_o,
  output logic                  r_last_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  input  logic                  w_valid_i,
  input  logic [ADDR_WIDTH-1:0] w_addr_i,
  input  logic [2:0]            w_size_i,
  input  logic [7:0]            w_len_i,
  input  logic [DATA_WIDTH-1:0] w_data_i,
  output logic                  w_ready_o,
  output logic                  w_last_o,
  ysyx_22041412_axi_dbridge_if.master axi
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD_AR = 3'd1;
  localparam logic [2:0] S_RD_R  = 3'd2;
  localparam logic [2:0] S_WR_AW = 3'd3;
  localparam logic [2:0] S_WR_W  = 3'd4;
  localparam logic [2:0] S_WR_B  = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [7:0]            len_q;
  logic [1:0]            size_q;
  logic [7:0]            cnt_q, cnt_d;
  logic                  r_ready_q;
  logic                  r_last_q;
  logic [DATA_WIDTH-1:0] r_data_q;
  logic                  w_last_q;

  logic       rd_hs;
  logic       w_hs;
  logic       wlast_c;
  logic [7:0] strb_base;
  logic [7:0] strb_shifted;
  logic       unused_size_msb;

  // Only B/H/W/D sizes exist for stores, so bit 2 of func3 carries no information.
  assign unused_size_msb = w_size_i[2];

  assign rd_hs   = (state_q == S_RD_R) && axi.rvalid;
  assign wlast_c = (state_q == S_WR_W) && (cnt_q == len_q);
  assign w_hs    = axi.wvalid && axi.wready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (w_valid_i) begin
          state_d = S_WR_AW;
        end else if (r_valid_i) begin
          state_d = S_RD_AR;
        end
      end
      S_RD_AR: if (axi.arready) state_d = S_RD_R;
      S_RD_R:  if (axi.rvalid && axi.rlast) state_d = S_DONE;
      S_WR_AW: if (axi.awready) state_d = S_WR_W;
      S_WR_W:  if (w_hs && wlast_c) state_d = S_WR_B;
      S_WR_B:  if (axi.bvalid) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_WR_AW) begin
      cnt_d = 8'd0;
    end else if (w_hs) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_comb begin
    case (size_q)
      2'd0:    strb_base = 8'h01;
      2'd1:    strb_base = 8'h03;
      2'd2:    strb_base = 8'h0F;
      default: strb_base = 8'hFF;
    endcase
  end

  // Sub-doubleword strobes only make sense for a single-beat store.
  assign strb_shifted = strb_base << addr_q[2:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      len_q     <= 8'd0;
      size_q    <= 2'd0;
      cnt_q     <= 8'd0;
      r_ready_q <= 1'b0;
      r_last_q  <= 1'b0;
      r_data_q  <= '0;
      w_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      r_ready_q <= rd_hs;
      r_last_q  <= rd_hs && axi.rlast;
      w_last_q  <= (state_q == S_WR_B) && axi.bvalid;
      if (rd_hs) begin
        r_data_q <= axi.rdata;
      end
      if (state_q == S_IDLE) begin
        if (w_valid_i) begin
          addr_q <= w_addr_i;
          len_q  <= w_len_i;
          size_q <= w_size_i[1:0];
        end else if (r_valid_i) begin
          addr_q <= r_addr_i;
          len_q  <= r_len_i;
        end
      end
    end
  end

  // Bus payloads are zeroed outside their own phase so an idle bridge drives all-zero.
  assign axi.arvalid = (state_q == S_RD_AR);
  assign axi.araddr  = (state_q == S_RD_AR) ? addr_q : '0;
  assign axi.arlen   = (state_q == S_RD_AR) ? len_q : 8'd0;
  assign axi.rready  = (state_q == S_RD_R);
  assign axi.awvalid = (state_q == S_WR_AW);
  assign axi.awaddr  = (state_q == S_WR_AW) ? addr_q : '0;
  assign axi.awlen   = (state_q == S_WR_AW) ? len_q : 8'd0;
  assign axi.wvalid  = (state_q == S_WR_W);
  assign axi.wdata   = (state_q == S_WR_W) ? w_data_i : '0;
  assign axi.wstrb   = (state_q != S_WR_W) ? 8'h00 :
                       (len_q == 8'd0)     ? strb_shifted : 8'hFF;
  assign axi.wlast   = wlast_c;
  assign axi.bready  = (state_q == S_WR_B);

  assign r_ready_o = r_ready_q;
  assign r_last_o  = r_last_q;
  assign r_data_o  = r_data_q;
  assign w_ready_o = w_hs;
  assign w_last_o  = w_last_q;

endmodule
